// File: rtl/mem_arbiter.sv
// Shares a single byte-wide memory port between three requesters (CPU, sprite
// engine, scanout). Only one transaction is in flight; arbitration is round-robin or fixed.
module mem_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned ADDR_WIDTH     = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [ADDR_WIDTH-1:0] idx0,
  input  logic [ADDR_WIDTH-1:0] idx1,
  input  logic [ADDR_WIDTH-1:0] idx2,
  input  logic [7:0]            wdata0,
  input  logic [7:0]            wdata1,
  input  logic [7:0]            wdata2,
  output logic [7:0]            rdata0,
  output logic [7:0]            rdata1,
  output logic [7:0]            rdata2,
  output logic [2:0]            ack,
  output logic [2:0]            grant,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_read_idx,
  input  logic [7:0]            mem_read_byte,
  input  logic                  mem_read_ack,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_write_idx,
  output logic [7:0]            mem_write_byte
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e                state_q, state_d;
  logic [1:0]            last_q, last_d;
  logic [2:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [2:0][7:0]       rdata_q, rdata_d;
  logic [1:0]            win;

  // Winner among requesters; only meaningful when some req bit is set.
  always_comb begin
    win = 2'd0;
    if (FIXED_PRIORITY != 0) begin
      if (req[0])      win = 2'd0;
      else if (req[1]) win = 2'd1;
      else             win = 2'd2;
    end else begin
      case (last_q)
        2'd0:    win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
        2'd1:    win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        default: win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= 2'd2;
      grant_q <= 3'b000;
      idx_q   <= '0;
      wdata_q <= 8'h00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d = 3'b001 << win;
          last_d  = win;
          case (win)
            2'd0:    begin idx_d = idx0; wdata_d = wdata0; end
            2'd1:    begin idx_d = idx1; wdata_d = wdata1; end
            default: begin idx_d = idx2; wdata_d = wdata2; end
          endcase
          state_d = we[win] ? StWrite : StRead;
        end
      end
      StWrite: begin
        state_d = StIdle;
        grant_d = 3'b000;
      end
      StRead: begin
        if (mem_read_ack) begin
          for (int p = 0; p < 3; p++) begin
            if (grant_q[p]) rdata_d[p] = mem_read_byte;
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = 3'b000;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode registered state only; no path from req or mem_read_ack.
  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    ack       = 3'b000;
    unique case (state_q)
      StWrite: begin
        mem_write = 1'b1;
        ack       = grant_q;
      end
      StRead:  mem_read = 1'b1;
      StDone:  ack = grant_q;
      default: ;
    endcase
  end

  assign grant          = grant_q;
  assign mem_read_idx   = idx_q;
  assign mem_write_idx  = idx_q;
  assign mem_write_byte = wdata_q;
  assign rdata0         = rdata_q[0];
  assign rdata1         = rdata_q[1];
  assign rdata2         = rdata_q[2];

endmodule
